// File: rtl/median_filter_3x3_pkg.sv
// Shared median-filter constants, used by the line buffer and the 3x3 filter.
package median_filter_3x3_pkg;

  localparam int MF_DATA_W      = 8;
  localparam int MF_IMAGE_WIDTH = 480;
  localparam int PIPE_LAT       = 4;
  // Columns at the start of a line whose window is still incomplete.
  localparam int PASS_COLS      = 2;

endpackage

// File: rtl/median_filter_3x3_sort3.sv
// Combinational three-input unsigned sorter: max / mid / min.
module sort3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] max_v,
  output logic [W-1:0] mid_v,
  output logic [W-1:0] min_v
);

  logic [W-1:0] ab_hi;
  logic [W-1:0] ab_lo;
  logic [W-1:0] r_lo;

  // Two-step compare network; on ties the earlier input wins the higher slot.
  always_comb begin
    ab_hi = (a >= b) ? a : b;
    ab_lo = (a >= b) ? b : a;
    max_v = (ab_hi >= c) ? ab_hi : c;
    r_lo  = (ab_hi >= c) ? c : ab_hi;
    mid_v = (ab_lo >= r_lo) ? ab_lo : r_lo;
    min_v = (ab_lo >= r_lo) ? r_lo : ab_lo;
  end

endmodule

// File: rtl/median_filter_3x3.sv
// 3x3 median filter: input capture, column window, column sort,
// row-stage reduction and final median, four cycles from sample to dout.
module median_filter_3x3
  import median_filter_3x3_pkg::*;
#(
  parameter int DATA_W      = MF_DATA_W,
  parameter int IMAGE_WIDTH = MF_IMAGE_WIDTH
) (
  input  logic              line_clk,
  input  logic              s_rst_n,
  input  logic              in_valid,
  input  logic              vsync,
  input  logic [DATA_W-1:0] taps0x,
  input  logic [DATA_W-1:0] taps1x,
  input  logic [DATA_W-1:0] taps2x,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMAGE_WIDTH - 1);

  logic [COL_W-1:0]           col;
  logic                       in_valid_d;

  logic                       in_v;
  logic                       in_pass;
  logic [2:0][DATA_W-1:0]     in_col;

  // win[k][r]: k=0 oldest column C0 .. k=2 newest C2, r = row
  logic [2:0][2:0][DATA_W-1:0] win;
  logic                       win_pass;
  logic [DATA_W-1:0]          win_px;

  logic [DATA_W-1:0]          cs_max [3];
  logic [DATA_W-1:0]          cs_mid [3];
  logic [DATA_W-1:0]          cs_min [3];
  logic [DATA_W-1:0]          srt_max [3];
  logic [DATA_W-1:0]          srt_mid [3];
  logic [DATA_W-1:0]          srt_min [3];
  logic                       srt_pass;
  logic [DATA_W-1:0]          srt_px;

  logic [DATA_W-1:0]          rs_max_of_mins;
  logic [DATA_W-1:0]          rs_med_of_mids;
  logic [DATA_W-1:0]          rs_min_of_maxs;
  logic [DATA_W-1:0]          max_of_mins;
  logic [DATA_W-1:0]          med_of_mids;
  logic [DATA_W-1:0]          min_of_maxs;
  logic                       row_pass;
  logic [DATA_W-1:0]          row_px;

  logic [DATA_W-1:0]          fin_med;
  logic [PIPE_LAT-1:0]        vld_sr;

  logic [DATA_W-1:0] unused_mins_mid, unused_mins_min;
  logic [DATA_W-1:0] unused_mids_max, unused_mids_min;
  logic [DATA_W-1:0] unused_maxs_max, unused_maxs_mid;
  logic [DATA_W-1:0] unused_fin_max, unused_fin_min;

  // Column position within the line: saturating count, cleared at line end or vsync.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      col        <= '0;
      in_valid_d <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      if (vsync || (!in_valid && in_valid_d))
        col <= '0;
      else if (in_valid && (col != COL_MAX))
        col <= col + 1'b1;
    end
  end

  // Capture one column of taps, tagged with whether its window is incomplete.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      in_v    <= 1'b0;
      in_pass <= 1'b0;
      in_col  <= '0;
    end else begin
      in_v <= in_valid;
      if (in_valid) begin
        in_col  <= {taps2x, taps1x, taps0x};
        in_pass <= (int'(col) < PASS_COLS);
      end
    end
  end

  // Shift the 3-column window on each captured column; hold otherwise.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      win      <= '0;
      win_pass <= 1'b0;
      win_px   <= '0;
    end else if (in_v) begin
      win      <= {in_col, win[2:1]};
      win_pass <= in_pass;
      win_px   <= in_col[1];
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_col_sort
    sort3 #(.W(DATA_W)) u_col_sort (
      .a     (win[k][0]),
      .b     (win[k][1]),
      .c     (win[k][2]),
      .max_v (cs_max[k]),
      .mid_v (cs_mid[k]),
      .min_v (cs_min[k])
    );
  end

  // Register the per-column sort results.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        srt_max[k] <= '0;
        srt_mid[k] <= '0;
        srt_min[k] <= '0;
      end
      srt_pass <= 1'b0;
      srt_px   <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        srt_max[k] <= cs_max[k];
        srt_mid[k] <= cs_mid[k];
        srt_min[k] <= cs_min[k];
      end
      srt_pass <= win_pass;
      srt_px   <= win_px;
    end
  end

  sort3 #(.W(DATA_W)) u_mins (
    .a (srt_min[0]), .b (srt_min[1]), .c (srt_min[2]),
    .max_v (rs_max_of_mins), .mid_v (unused_mins_mid), .min_v (unused_mins_min)
  );

  sort3 #(.W(DATA_W)) u_mids (
    .a (srt_mid[0]), .b (srt_mid[1]), .c (srt_mid[2]),
    .max_v (unused_mids_max), .mid_v (rs_med_of_mids), .min_v (unused_mids_min)
  );

  sort3 #(.W(DATA_W)) u_maxs (
    .a (srt_max[0]), .b (srt_max[1]), .c (srt_max[2]),
    .max_v (unused_maxs_max), .mid_v (unused_maxs_mid), .min_v (rs_min_of_maxs)
  );

  // Register the row-stage reduction.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      max_of_mins <= '0;
      med_of_mids <= '0;
      min_of_maxs <= '0;
      row_pass    <= 1'b0;
      row_px      <= '0;
    end else begin
      max_of_mins <= rs_max_of_mins;
      med_of_mids <= rs_med_of_mids;
      min_of_maxs <= rs_min_of_maxs;
      row_pass    <= srt_pass;
      row_px      <= srt_px;
    end
  end

  sort3 #(.W(DATA_W)) u_final (
    .a (max_of_mins), .b (med_of_mids), .c (min_of_maxs),
    .max_v (unused_fin_max), .mid_v (fin_med), .min_v (unused_fin_min)
  );

  // Output register: median, or the raw centre-row pixel while the window fills.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n)
      dout <= '0;
    else
      dout <= row_pass ? row_px : fin_med;
  end

  // Valid tracking alongside the data stages; gaps propagate unchanged.
  always_ff @(posedge line_clk or negedge s_rst_n) begin
    if (!s_rst_n)
      vld_sr <= '0;
    else
      vld_sr <= {vld_sr[PIPE_LAT-2:0], in_v};
  end

  assign dout_valid = vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_median_filter_3x3.sv
// Scoreboard bench for median_filter_3x3 with directed columns.
module tb_median_filter_3x3;

  logic       line_clk = 1'b0;
  logic       s_rst_n  = 1'b0;
  logic       in_valid = 1'b0;
  logic       vsync    = 1'b0;
  logic [7:0] taps0x   = '0;
  logic [7:0] taps1x   = '0;
  logic [7:0] taps2x   = '0;
  logic [7:0] dout;
  logic       dout_valid;

  median_filter_3x3 #(.DATA_W(8), .IMAGE_WIDTH(480)) dut (
    .line_clk   (line_clk),
    .s_rst_n    (s_rst_n),
    .in_valid   (in_valid),
    .vsync      (vsync),
    .taps0x     (taps0x),
    .taps1x     (taps1x),
    .taps2x     (taps2x),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 line_clk = ~line_clk;

  int cyc = 0;
  always @(posedge line_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] v;
    int         s;
  } exp_t;

  exp_t q[$];
  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected entry, 4 cycles after sampling.
  always @(negedge line_clk) begin : mon
    exp_t e;
    if (s_rst_n && dout_valid) begin
      pulses++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("dout", int'(dout), int'(e.v));
        chk("latency", cyc - e.s, 4);
      end
    end
  end

  task automatic send(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                      input logic [7:0] ex, input logic vs = 1'b0);
    exp_t e;
    @(posedge line_clk);
    #1;
    in_valid = 1'b1;
    vsync    = vs;
    taps0x   = t0;
    taps1x   = t1;
    taps2x   = t2;
    e.v = ex;
    e.s = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge line_clk);
      #1;
      in_valid = 1'b0;
      vsync    = 1'b0;
      taps0x   = '0;
      taps1x   = '0;
      taps2x   = '0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    chk(name, q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge line_clk);
    #1;
    s_rst_n  = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #2;
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    repeat (3) @(posedge line_clk);
    #1;
    s_rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("por_dout", int'(dout), 0);
    chk("por_dout_valid", int'(dout_valid), 0);
    @(posedge line_clk);
    #1;
    s_rst_n = 1'b1;
    idle(2);

    // Constant 0x5A across a full line.
    pulses = 0;
    for (int i = 0; i < 480; i++) send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    drain("const_drain");
    chk("const_pulses", pulses, 480);

    // Impulse in the centre row at col 10 of a zero field.
    for (int i = 0; i < 20; i++) send(8'h00, (i == 10) ? 8'hFF : 8'h00, 8'h00, 8'h00);
    drain("impulse_drain");

    // Worked window: pass-through of the centre row, then median 5 and 6.
    send(8'd9, 8'd1, 8'd5, 8'd1);
    send(8'd2, 8'd8, 8'd3, 8'd8);
    send(8'd7, 8'd4, 8'd6, 8'd5);
    send(8'd7, 8'd4, 8'd6, 8'd6);
    drain("window_drain");

    // Pass-through at line start, repeated after a line gap.
    for (int l = 0; l < 2; l++) begin
      send(8'h00, 8'h11, 8'h00, 8'h11);
      send(8'h00, 8'h22, 8'h00, 8'h22);
      idle(3);
    end
    drain("pass_drain");

    // Valid gaps on a constant field: 1,1,1,1 then 1,0,1,1.
    for (int i = 0; i < 4; i++) send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    idle(1);
    send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    drain("gap_drain");

    // vsync mid-line: in-flight data still emerges, col restarts.
    for (int i = 0; i < 4; i++) send(8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    send(8'h00, 8'h77, 8'h00, 8'h77);
    send(8'h00, 8'h66, 8'h00, 8'h66);
    send(8'h00, 8'h55, 8'h00, 8'h00);
    drain("vsync_drain");

    // Reset mid-line discards in-flight columns; next line passes through from col 0.
    pulses = 0;
    send(8'h21, 8'h21, 8'h21, 8'h21);
    send(8'h21, 8'h21, 8'h21, 8'h21);
    send(8'h21, 8'h21, 8'h21, 8'h21);
    pulse_reset();
    idle(8);
    chk("reset_discard_pulses", pulses, 0);
    send(8'h00, 8'h33, 8'h00, 8'h33);
    send(8'h00, 8'h44, 8'h00, 8'h44);
    drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/median_filter_3x3.md
MEDIAN_FILTER_3X3 -- requirements
Module: median_filter_3x3

Interface
REQ-001 Parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 Parameter IMAGE_WIDTH, default 480, meaning pixels per line, used to saturate the column counter.
REQ-003 line_clk  input  1  pixel clock; all logic runs on rising edge; one clock only.
REQ-004 s_rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  high while taps0x/taps1x/taps2x carry one window column per cycle (driven by the line-buffer done).
REQ-006 vsync  input  1  frame sync; high level clears line state.
REQ-007 taps0x  input  DATA_W  oldest line (row y-1) pixel.
REQ-008 taps1x  input  DATA_W  middle line (row y) pixel; window centre row.
REQ-009 taps2x  input  DATA_W  newest line (row y+1) pixel.
REQ-010 dout  output  DATA_W  filtered pixel.
REQ-011 dout_valid  output  1  high for exactly one cycle per accepted input column.

Function
REQ-012 The block SHALL sample the three taps as one column when in_valid=1 and SHALL ignore taps when in_valid=0.
REQ-013 Window stage: three column registers C0 (oldest) to C2 (newest) SHALL shift by one column on each sampled column; no shift when in_valid=0.
REQ-014 Column counter col SHALL increment per sampled column, saturate at IMAGE_WIDTH-1, and clear to 0 on the first cycle with in_valid=0 after in_valid=1 (line end) or when vsync=1.
REQ-015 Stage 2: each column SHALL be sorted into (max, mid, min) by three sort3 instances, registered.
REQ-016 Stage 3: registered max_of_mins = max of three column mins, med_of_mids = median of three mids, min_of_maxs = min of three maxes.
REQ-017 Stage 4: dout SHALL be the registered median of (max_of_mins, med_of_mids, min_of_maxs).
REQ-018 Latency SHALL be exactly 4 cycles: column sampled at edge N yields dout_valid=1 and dout after edge N+4.
REQ-019 Output centre pixel SHALL correspond to column C1 (the column sampled one before the newest).
REQ-020 For columns with col<2 (window incomplete), dout SHALL equal the delayed C1 middle-row pixel (pass-through), still at latency 4.
REQ-021 A valid-bit shift register of depth 4 SHALL track in_valid; gaps in in_valid SHALL propagate as gaps in dout_valid with no data reordering.
REQ-022 All comparisons SHALL be unsigned on DATA_W bits; equal values SHALL order deterministically (ties keep input order) so results are bit-exact with a software reference.
REQ-023 vsync asserted mid-line SHALL clear col but SHALL NOT flush in-flight pipeline data; outputs already sampled SHALL still emerge.

Reset
REQ-024 While s_rst_n=0 all registers SHALL clear: dout=0, dout_valid=0, col=0, window and pipeline registers=0.
REQ-025 After release, the first sampled column SHALL be treated as col=0; no dout_valid SHALL occur before 4 cycles after the first in_valid.
REQ-026 Reset asserted mid-line SHALL discard all in-flight pixels with no partial output.

Structure
REQ-027 DATA_W, IMAGE_WIDTH default and PIPE_LAT=4 SHALL live in the shared median-filter constants file used by the line buffer and this block.
REQ-028 One sub-module sort3 (three DATA_W inputs, outputs max/mid/min, combinational) SHALL be instantiated for column sort and reused for row stage and final median.
REQ-029 The pipeline SHALL have no backpressure; the consumer SHALL accept one pixel per cycle.

Verification
REQ-030 Constant image value 0x5A, full 480-pixel line -> every dout=0x5A, 480 dout_valid pulses, first 4 cycles after first in_valid.
REQ-031 Single impulse 0xFF at row y centre in zero field, col 10 -> dout=0x00 at that position, no 0xFF anywhere after col>=2.
REQ-032 Columns (rows 0,1,2) = (9,1,5),(2,8,3),(7,4,6) at col>=2 -> dout=5 four cycles after third column.
REQ-033 First two columns of line with taps1x=0x11,0x22 -> dout=0x11,0x22 pass-through; line gap then new line -> col restarts, pass-through repeats.
REQ-034 in_valid toggling 1,0,1,1 -> dout_valid pattern identical shifted by 4 cycles, values unchanged versus continuous feed.
REQ-035 s_rst_n pulsed low mid-line -> dout=0, dout_valid=0 immediately; next line output restarts with pass-through at col 0.
